// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and helpers for the EX-stage forwarding/interlock scoreboard.
// Entry fields use fixed maximum widths; narrower tags and latencies are zero-extended into them.
package fwd_pkg;

    localparam int TAG_MAX_W = 8;
    localparam int CNT_MAX_W = 8;
    localparam int MAX_ENT   = 16;
    localparam int IDX_W     = 4;

    localparam logic [CNT_MAX_W-1:0] LAT_ALU  = 8'd0;
    localparam logic [CNT_MAX_W-1:0] LAT_LOAD = 8'd1;
    localparam logic [TAG_MAX_W-1:0] TAG_ZERO = 8'd0;

    typedef struct packed {
        logic                 v;
        logic                 we;
        logic [TAG_MAX_W-1:0] rd;
        logic [CNT_MAX_W-1:0] cnt;
    } entry_t;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } pick_t;

    function automatic logic tag_match(input entry_t e, input logic [TAG_MAX_W-1:0] t);
        return e.v & e.we & (e.rd == t) & (t != TAG_ZERO);
    endfunction

    // Lowest set bit wins: index 0 is always the youngest producer.
    function automatic pick_t prio_first(input logic [MAX_ENT-1:0] m);
        pick_t p;
        p.hit = 1'b0;
        p.idx = '0;
        for (int i = MAX_ENT - 1; i >= 0; i--) begin
            if (m[i]) begin
                p.hit = 1'b1;
                p.idx = IDX_W'(i);
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

    function automatic logic [CNT_MAX_W-1:0] cnt_dec(input logic [CNT_MAX_W-1:0] c);
        return (c == '0) ? c : c - 8'd1;
    endfunction

endpackage

// File: rtl/fwd_scoreboard_select.sv
// Priority match and data mux for one source operand across the tracked producer stages.
module fwd_select
    import fwd_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int DW    = 32
) (
    input  logic                  en_i,
    input  logic [TAG_MAX_W-1:0]  tag_i,
    input  entry_t [DEPTH-1:0]    ent_i,
    input  logic [DEPTH*DW-1:0]   stage_data_i,
    input  logic [DW-1:0]         reg_data_i,
    output logic [DW-1:0]         data_o,
    output logic                  hit_o
);

    logic [MAX_ENT-1:0] match_s;
    pick_t              pick_s;
    logic [DW-1:0]      sel_s;

    // Youngest matching stage drives the operand; otherwise the register-file copy.
    always_comb begin
        match_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match_s[k] = tag_match(ent_i[k], tag_i);
        end
        pick_s = prio_first(match_s);
        sel_s  = reg_data_i;
        for (int k = 0; k < DEPTH; k++) begin
            if (pick_s.idx == IDX_W'(k)) begin
                sel_s = stage_data_i[k*DW +: DW];
            end else begin
                sel_s = sel_s;
            end
        end
        if (en_i && pick_s.hit) begin
            data_o = sel_s;
            hit_o  = 1'b1;
        end else begin
            data_o = reg_data_i;
            hit_o  = 1'b0;
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// EX-stage forwarding and load-use interlock: tracks in-flight destinations and latencies
// through a DEPTH-entry shift pipeline, forwards the youngest producer, stalls ID when needed.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int LW      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  flush_ex,
    input  logic                  id_valid,
    input  logic                  id_we,
    input  logic [AW-1:0]         id_rd,
    input  logic [LW-1:0]         id_lat,
    input  logic [NUM_SRC*AW-1:0] id_rs,
    input  logic [DEPTH*DW-1:0]   stage_data,
    input  logic [NUM_SRC*DW-1:0] ex_reg_data,
    output logic                  stall,
    output logic [NUM_SRC*DW-1:0] fwd_data,
    output logic [NUM_SRC-1:0]    fwd_hit
);

    entry_t                ex_q, ex_d;
    logic [NUM_SRC*AW-1:0] ex_rs_q, ex_rs_d;
    entry_t [DEPTH-1:0]    trk_q, trk_d;
    logic [CNT_MAX_W-1:0]  lat_s;
    logic [NUM_SRC-1:0]    stall_src_s;

    // Clamping keeps every producer ready before it leaves T[DEPTH-1].
    assign lat_s = (id_lat >= LW'(DEPTH)) ? CNT_MAX_W'(DEPTH - 1) : CNT_MAX_W'(id_lat);
    assign stall = |stall_src_s;

    // Per-source forwarding mux and load-use check.
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [MAX_ENT-1:0]   ilk_m_s;
        pick_t                ilk_p_s;
        logic [TAG_MAX_W-1:0] id_tag_s;
        logic                 stall_one_s;

        fwd_select #(
            .DEPTH (DEPTH),
            .DW    (DW)
        ) u_sel (
            .en_i         (ex_q.v),
            .tag_i        (TAG_MAX_W'(ex_rs_q[s*AW +: AW])),
            .ent_i        (trk_q),
            .stage_data_i (stage_data),
            .reg_data_i   (ex_reg_data[s*DW +: DW]),
            .data_o       (fwd_data[s*DW +: DW]),
            .hit_o        (fwd_hit[s])
        );

        // Only the youngest match counts; T[DEPTH-1] is excluded since it retires next advance.
        always_comb begin
            id_tag_s   = TAG_MAX_W'(id_rs[s*AW +: AW]);
            ilk_m_s    = '0;
            ilk_m_s[0] = tag_match(ex_q, id_tag_s);
            for (int k = 0; k < DEPTH - 1; k++) begin
                ilk_m_s[k+1] = tag_match(trk_q[k], id_tag_s);
            end
            ilk_p_s     = prio_first(ilk_m_s);
            stall_one_s = 1'b0;
            if (!id_valid || !ilk_p_s.hit) begin
                stall_one_s = 1'b0;
            end else if (ilk_p_s.idx == '0) begin
                stall_one_s = (ex_q.cnt != '0);
            end else begin
                for (int k = 0; k < DEPTH - 1; k++) begin
                    if (ilk_p_s.idx == IDX_W'(k + 1)) begin
                        stall_one_s = (trk_q[k].cnt > CNT_MAX_W'(1));
                    end else begin
                        stall_one_s = stall_one_s;
                    end
                end
            end
        end

        assign stall_src_s[s] = stall_one_s;
    end

    // Advance: shift the tracker, age latencies, and load EX from ID or a bubble.
    always_comb begin
        ex_d    = ex_q;
        ex_rs_d = ex_rs_q;
        trk_d   = trk_q;
        if (!hold) begin
            trk_d[0] = ex_q;
            for (int k = 1; k < DEPTH; k++) begin
                trk_d[k]     = trk_q[k-1];
                trk_d[k].cnt = cnt_dec(trk_q[k-1].cnt);
            end
            if (stall || flush_ex) begin
                ex_d    = '0;
                ex_rs_d = '0;
            end else begin
                ex_d.v   = id_valid;
                ex_d.we  = id_we;
                ex_d.rd  = TAG_MAX_W'(id_rd);
                ex_d.cnt = lat_s;
                ex_rs_d  = id_rs;
            end
        end else begin
            ex_d = ex_q;
        end
    end

    // Tracker registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            ex_rs_q <= '0;
            trk_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            ex_rs_q <= ex_rs_d;
            trk_q   <= trk_d;
        end
    end

endmodule
